// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the fetch FSM state type, default widths and the absolute jump-target table that the
// jump_lut sub-module reads. Entries not listed below are 0.
package fetch_unit_pkg;

  localparam int unsigned kPcW     = 10;
  localparam int unsigned kLutIdxW = 5;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } fetch_state_t;

  // Absolute jump targets indexed by the instruction's JumpIdx field (index 0 first).
  localparam logic [kPcW-1:0] kJumpTargets [2**kLutIdxW] = '{
    10'd0,    10'd16,   10'd50,   10'd100,  10'd1020, 10'd7,    10'd0,    10'd0,
    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,
    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,
    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0,    10'd0
  };

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Combinational jump-target lookup.
// Ports:
//   JumpIdx - instruction field selecting the jump target
//   Target  - absolute PC of the selected target
// Kept separate so a program-specific table can be swapped without touching the fetch FSM.
module jump_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W      = kPcW,
  parameter int unsigned LUT_IDX_W = kLutIdxW
) (
  input  logic [LUT_IDX_W-1:0] JumpIdx,
  output logic [PC_W-1:0]      Target
);

  always_comb begin
    Target = PC_W'(kJumpTargets[JumpIdx]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, sequences start/run/halt and applies
// taken jumps from the decoder.
// Ports:
//   Clk, Reset          - clock and asynchronous active-high reset
//   Start               - (re)arm and begin the program at PC 0
//   Ack                 - decoder halt indication
//   Jump, Taken, JumpIdx - conditional jump request, ALU condition, target index
//   ProgCtr             - current instruction address
//   Running, Done       - registered state decodes
//   CycleCnt            - saturating count of RUN cycles in the current/last program
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W      = kPcW,
  parameter int unsigned LUT_IDX_W = kLutIdxW,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic                 Jump,
  input  logic                 Taken,
  input  logic [LUT_IDX_W-1:0] JumpIdx,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 Running,
  output logic                 Done,
  output logic [CNT_W-1:0]     CycleCnt
);

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  target;

  jump_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_jump_lut (
    .JumpIdx (JumpIdx),
    .Target  (target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (Start) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        pc_d  = '0;
        cnt_d = '0;
        if (!Start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Saturating count of every edge spent in RUN, including the halting one.
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (Start) begin
          state_d = ARM;
          pc_d    = '0;
          // Cleared on entry so CycleCnt already reads 0 while in ARM.
          cnt_d   = '0;
        end else if (Ack) begin
          // Halt wins over a simultaneous taken jump; PC stays on the halt address.
          state_d = DONE;
        end else if (Jump && Taken) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      DONE: begin
        if (Start) begin
          state_d = ARM;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ProgCtr  = pc_q;
  assign CycleCnt = cnt_q;
  assign Running  = (state_q == RUN);
  assign Done     = (state_q == DONE);

endmodule
